// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared full-adder bit functions and constants
package adder_pkg;

   // Number of distinct {a,b,c} input combinations tracked by the coverage mask
   localparam int NUM_COMBOS = 8;

   // Sum bit of a 1-bit full adder
   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   // Carry bit of a 1-bit full adder: majority of the three inputs
   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/full_adder_core.sv
// rtl/full_adder_core.sv - purely combinational 1-bit full adder cell
module full_adder_core
   import adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic cout
);

   // Zero-latency sum/carry so ripple chains can cascade cells directly
   assign s    = fa_sum(a, b, c);
   assign cout = fa_carry(a, b, c);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - full adder with capture registers, coverage mask and carry counter
module full_adder
   import adder_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a,
   input  logic                  b,
   input  logic                  c,
   input  logic                  en,
   input  logic                  clr,
   output logic                  s,
   output logic                  cout,
   output logic                  s_q,
   output logic                  cout_q,
   output logic                  valid_q,
   output logic [NUM_COMBOS-1:0] cov,
   output logic                  all_cov,
   output logic [CNT_W-1:0]      carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0] combo;

   full_adder_core u_core (
      .a    (a),
      .b    (b),
      .c    (c),
      .s    (s),
      .cout (cout)
   );

   // Coverage index uses a as the most significant bit
   assign combo = {a, b, c};

   // Every combination seen once the whole mask is populated
   assign all_cov = &cov;

   // Capture stage: valid follows en every cycle, data holds when en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= 1'b0;
         cout_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= en;
         if (en) begin
            s_q    <= s;
            cout_q <= cout;
         end
      end
   end

   // Statistics: clr wins over en; counter saturates instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cov       <= '0;
         carry_cnt <= '0;
      end else if (clr) begin
         cov       <= '0;
         carry_cnt <= '0;
      end else if (en) begin
         cov[combo] <= 1'b1;
         if (cout && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - randomized self-checking bench for full_adder against an arithmetic model
module tb_full_adder;

   logic       clk;
   logic       rst_n;
   logic       a, b, c, en, clr;

   logic       s, cout, s_q, cout_q, valid_q, all_cov;
   logic [7:0] cov;
   logic [7:0] carry_cnt;

   logic       s2, cout2, s_q2, cout_q2, valid_q2, all_cov2;
   logic [7:0] cov2;
   logic [1:0] carry_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   bit m_seen[8];
   int m_cnt8, m_cnt2;
   bit m_s, m_cout, m_valid;

   full_adder #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en), .clr(clr),
      .s(s), .cout(cout), .s_q(s_q), .cout_q(cout_q), .valid_q(valid_q),
      .cov(cov), .all_cov(all_cov), .carry_cnt(carry_cnt)
   );

   full_adder #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en), .clr(clr),
      .s(s2), .cout(cout2), .s_q(s_q2), .cout_q(cout_q2), .valid_q(valid_q2),
      .cov(cov2), .all_cov(all_cov2), .carry_cnt(carry_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_seen[i] = 0;
      m_cnt8 = 0; m_cnt2 = 0;
      m_s = 0; m_cout = 0; m_valid = 0;
   endtask

   function automatic int ones();
      return int'(a) + int'(b) + int'(c);
   endfunction

   task automatic check_comb();
      check("s", 32'(s), 32'(ones() % 2));
      check("cout", 32'(cout), 32'(ones() >= 2));
      check("s_w2", 32'(s2), 32'(ones() % 2));
      check("cout_w2", 32'(cout2), 32'(ones() >= 2));
   endtask

   task automatic check_regs();
      logic [7:0] exp_cov;
      bit         exp_all;
      exp_all = 1;
      for (int i = 0; i < 8; i++) begin
         exp_cov[i] = m_seen[i];
         if (!m_seen[i]) exp_all = 0;
      end
      check("s_q", 32'(s_q), 32'(m_s));
      check("cout_q", 32'(cout_q), 32'(m_cout));
      check("valid_q", 32'(valid_q), 32'(m_valid));
      check("cov", 32'(cov), 32'(exp_cov));
      check("all_cov", 32'(all_cov), 32'(exp_all));
      check("carry_cnt", 32'(carry_cnt), 32'(m_cnt8));
      check("cov_w2", 32'(cov2), 32'(exp_cov));
      check("carry_cnt_w2", 32'(carry_cnt2), 32'(m_cnt2));
   endtask

   // drive inputs mid-cycle and check the combinational path
   task automatic apply(input logic ia, input logic ib, input logic ic, input logic ien, input logic iclr);
      a = ia; b = ib; c = ic; en = ien; clr = iclr;
      #1;
      check_comb();
   endtask

   // one rising edge: advance model from the applied inputs, then check 1 unit later
   task automatic tick();
      int n;
      @(posedge clk);
      n = ones();
      m_valid = en;
      if (en) begin
         m_s = (n % 2) != 0;
         m_cout = n >= 2;
      end
      if (clr) begin
         for (int i = 0; i < 8; i++) m_seen[i] = 0;
         m_cnt8 = 0; m_cnt2 = 0;
      end else if (en) begin
         m_seen[n == 0 ? 0 : (int'(a) * 4 + int'(b) * 2 + int'(c))] = 1;
         if (n >= 2) begin
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
         end
      end
      #1;
      check_regs();
   endtask

   // pulse reset between edges; must clear immediately
   task automatic async_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_regs();
      check_comb();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [2:0] sweep [8];
      sweep = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};

      rst_n = 1'b0; a = 0; b = 0; c = 0; en = 1; clr = 0;
      model_reset();
      #3 check_regs();
      @(posedge clk);
      #1 check_regs();
      #2 rst_n = 1'b1;
      en = 0;

      // combinational sweep with capture disabled
      foreach (sweep[i]) begin
         apply(sweep[i][2], sweep[i][1], sweep[i][0], 1'b0, 1'b0);
         tick();
      end

      // capture then hold
      apply(1, 1, 0, 1, 0);
      tick();
      check("cap_cout_q", 32'(cout_q), 32'd1);
      apply(0, 0, 1, 0, 0);
      tick();
      check("hold_cout_q", 32'(cout_q), 32'd1);

      // full coverage on consecutive edges
      apply(0, 0, 0, 0, 1);
      tick();
      foreach (sweep[i]) begin
         apply(sweep[i][2], sweep[i][1], sweep[i][0], 1'b1, 1'b0);
         tick();
      end
      check("cov_full", 32'(cov), 32'hFF);
      check("cnt_four", 32'(carry_cnt), 32'd4);

      // async reset mid-run
      async_reset();
      check("rst_cov", 32'(cov), 32'h0);

      // saturation on the narrow counter
      for (int i = 0; i < 6; i++) begin
         apply(1, 1, 1, 1, 0);
         tick();
      end
      check("sat_w2", 32'(carry_cnt2), 32'd3);

      // clr priority over en
      apply(1, 1, 1, 1, 1);
      tick();
      check("clr_cnt", 32'(carry_cnt), 32'd0);

      // randomized run
      for (int i = 0; i < 400; i++) begin
         apply(1'($urandom), 1'($urandom), 1'($urandom),
               1'(($urandom % 4) != 0), 1'(($urandom % 32) == 0));
         tick();
         if (($urandom % 64) == 0) async_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
